rd_sync_fifo: RTL and testbench
===============================

Name: rd_sync_fifo

Overview:
Single-clock FIFO in the read-clock domain. It sits between the async FIFO's read port and the FIR datapath, and re-buffers samples for rate smoothing. It generalises the existing FIFO with:
- selectable first-word-fall-through (FWFT) or standard read mode
- programmable almost-full/almost-empty thresholds
- a live occupancy count
- sticky overflow/underflow error flags

Parameters:
WIDTH, 5, data word width in bits (>=1)
DEPTH, 16, number of storage words; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
r_clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-high
w_en  in  1  write request
i_dat  in  WIDTH  write data
r_en  in  1  read request (standard mode) / head acknowledge (FWFT)
clr_err  in  1  clears sticky error flags
o_dat  out  WIDTH  read data
o_valid  out  1  o_dat carries a freshly read word
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
empty  out  1  count == 0
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  words currently stored
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Storage: flop array of DEPTH x WIDTH, addressed by write/read pointers of $clog2(DEPTH)+1 bits.
  - The MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
  - count = wptr - rptr, unsigned, modulo 2*DEPTH.
- Status outputs full, empty, almost_full, almost_empty and count are decoded from registered pointers only. They are glitch-free and reflect the state after the last edge.
- Read accept: rd_acc = r_en & ~empty.
- Write accept: wr_acc = w_en & (~full | rd_acc).
  - Write while full is allowed when a read is accepted in the same cycle.
  - Read while empty is never accepted, even with a simultaneous write.
- Simultaneous write and read accepted: count unchanged; both pointers advance.
- Standard mode (FWFT=0):
  - On rd_acc, o_dat <= mem[rptr] and o_valid <= 1 at the same edge (1-cycle latency from r_en).
  - Otherwise o_valid <= 0 and o_dat holds its last value. Reading when empty leaves o_dat stuck.
- FWFT mode (FWFT=1):
  - o_dat = mem[rptr], combinational from registered state.
  - o_valid = ~empty.
  - A word written at edge k is visible on o_dat with o_valid=1 immediately after edge k.
  - r_en pops the head; the next word, if any, appears after that edge.
- Errors:
  - overflow <= 1 on w_en & full & ~rd_acc; the data is dropped and memory is not modified.
  - underflow <= 1 on r_en & empty.
  - clr_err clears both flags. If set and clear occur in the same cycle, set wins.
- Reset (async assert, released synchronously by the upstream reset synchroniser):
  - wptr = rptr = 0, count = 0
  - empty = 1, almost_empty = 1 (AE_THRESH >= 0)
  - full = 0, almost_full = 0
  - o_dat = 0, o_valid = 0 (FWFT: o_valid = ~empty = 0)
  - overflow = 0, underflow = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words; the first post-reset read returns the first post-reset write.
- Thresholds are static. Illegal parameter values (non-power-of-two DEPTH, thresholds out of range) trigger an elaboration-time $error.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_w(DEPTH) = $clog2(DEPTH)+1
  - localparams for the mode encodings FWFT_OFF=0 and FWFT_ON=1
  - the reset value for o_dat
- One natural sub-module: fifo_ptr_ctrl. It owns the pointers, the accept logic, count/flag decode and the sticky errors.
- The top level holds the storage array and the mode-dependent output stage.

Test Plan:
1. FWFT=0, reset, then write 21 words i+7 (7..27) back-to-back. Required:
   - full after the 16th write, almost_full from count 14
   - count == 16
   - overflow = 1
   - memory holds 7..22
2. Continue from 1: r_en held for 21 cycles. Required:
   - o_dat = 7..22 in order, each with o_valid one cycle after r_en
   - empty after the 16th read, underflow = 1
   - o_dat stays 22 and o_valid = 0 thereafter
3. FWFT=1, empty FIFO, single write of 5. Required:
   - o_dat = 5 and o_valid = 1 right after the write edge
   - r_en one cycle later gives empty = 1 and o_valid = 0
4. FWFT=0 at full (16 words), w_en and r_en together with i_dat = 30. Required:
   - write accepted, count stays 16, no overflow
   - after draining, 30 is the last word read
5. Mid-stream rst pulse with count = 9, error flags set. Required:
   - count = 0, empty = 1, overflow = underflow = 0, o_valid = 0
   - next write 12 then read returns 12
6. clr_err asserted in the same cycle as a new overflow event -> overflow remains 1; clr_err alone on the next cycle -> overflow = 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the read-domain synchronous FIFO: pointer sizing,
// read-mode encodings and the output data reset value.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Every bit of o_dat resets to this value.
    localparam logic ODAT_RST_BIT = 1'b0;

    // One extra MSB beyond the address bits lets full and empty be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, accept, occupancy/flag decode and sticky error logic for rd_sync_fifo.
// Status outputs are decoded purely from the registered pointers.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int PW       = ptr_w(DEPTH),
    localparam int AW       = PW - 1
) (
    input  logic          r_clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic          r_en,
    input  logic          clr_err,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic          almost_empty,
    output logic [PW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Pointers span 2*DEPTH, so plain subtraction wraps to the true occupancy.
    assign count        = wptr - rptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign waddr = wptr[AW-1:0];
    assign raddr = rptr[AW-1:0];

    // A write into a full FIFO is fine when a read frees a slot in the same cycle.
    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PW'(1);
            if (rd_acc) rptr <= rptr + PW'(1);

            // A new error event in the same cycle as clr_err keeps the flag set.
            if (w_en & full & ~rd_acc) overflow <= 1'b1;
            else if (clr_err)          overflow <= 1'b0;

            if (r_en & empty)          underflow <= 1'b1;
            else if (clr_err)          underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/rd_sync_fifo.sv
// Read-domain re-buffering FIFO between the async FIFO and the FIR datapath,
// with standard or first-word-fall-through read mode.
module rd_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     r_clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     r_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = ptr_w(DEPTH) - 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("rd_sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rd_sync_fifo: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("rd_sync_fifo: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("rd_sync_fifo: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_mode
        $error("rd_sync_fifo: FWFT must be 0 or 1");
    end

    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_ptr_ctrl (
        .r_clk        (r_clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .waddr        (waddr),
        .raddr        (raddr),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the pointers alone decide which
    // words are valid, so clearing it would only cost a reset net on every bit.
    always_ff @(posedge r_clk) begin
        if (wr_acc) mem[waddr] <= i_dat;
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head word is presented directly; r_en only acknowledges it.
        logic unused_rd_acc;
        assign unused_rd_acc = rd_acc;
        assign o_dat         = mem[raddr];
        assign o_valid       = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] dat_q;
        logic             valid_q;

        // o_dat holds its last word when nothing is read.
        always_ff @(posedge r_clk or posedge rst) begin
            if (rst) begin
                dat_q   <= {WIDTH{ODAT_RST_BIT}};
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) dat_q <= mem[raddr];
            end
        end

        assign o_dat   = dat_q;
        assign o_valid = valid_q;
    end

endmodule

// File: tb/tb_rd_sync_fifo.sv
// Self-checking bench: a standard-mode and an FWFT instance share stimulus and
// are compared against one queue-based reference model with an output scoreboard.
module tb_rd_sync_fifo;

    localparam int W  = 5;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;
    localparam int CW = $clog2(D) + 1;

    logic          r_clk;
    logic          rst;
    logic          w_en;
    logic [W-1:0]  i_dat;
    logic          r_en;
    logic          clr_err;

    logic [W-1:0]  o_dat_s, o_dat_f;
    logic          o_valid_s, o_valid_f;
    logic          full_s, full_f, af_s, af_f, empty_s, empty_f, ae_s, ae_f;
    logic [CW-1:0] count_s, count_f;
    logic          ovf_s, ovf_f, unf_s, unf_f;

    rd_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_std (
        .r_clk(r_clk), .rst(rst), .w_en(w_en), .i_dat(i_dat), .r_en(r_en),
        .clr_err(clr_err), .o_dat(o_dat_s), .o_valid(o_valid_s), .full(full_s),
        .almost_full(af_s), .empty(empty_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    rd_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
        .r_clk(r_clk), .rst(rst), .w_en(w_en), .i_dat(i_dat), .r_en(r_en),
        .clr_err(clr_err), .o_dat(o_dat_f), .o_valid(o_valid_f), .full(full_f),
        .almost_full(af_f), .empty(empty_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored words, words owed on the standard output, sticky flags.
    logic [W-1:0] mq[$];
    logic [W-1:0] sb[$];
    logic         m_ovf, m_unf;
    logic [W-1:0] m_last;

    typedef struct {
        logic         we;
        logic [W-1:0] d;
        logic         re;
        logic         ce;
        int           e_count;
        logic         e_valid;
        logic [W-1:0] e_dat;
        logic         e_unf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Flags packed as {full, almost_full, empty, almost_empty, overflow, underflow}.
    function automatic logic [5:0] model_flags();
        int n;
        n = mq.size();
        return {n == D, n >= AF, n == 0, n <= AE, m_ovf, m_unf};
    endfunction

    task automatic check_outputs(input logic racc);
        logic [W-1:0] exp_dat;
        check("std_count", count_s, mq.size());
        check("fwft_count", count_f, mq.size());
        check("std_flags", {full_s, af_s, empty_s, ae_s, ovf_s, unf_s}, model_flags());
        check("fwft_flags", {full_f, af_f, empty_f, ae_f, ovf_f, unf_f}, model_flags());
        check("std_valid", o_valid_s, racc);
        if (racc) begin
            if (sb.size() == 0) begin
                check("std_scoreboard_empty", 1, 0);
            end else begin
                exp_dat = sb.pop_front();
                m_last  = exp_dat;
            end
        end
        check("std_dat", o_dat_s, m_last);
        check("fwft_valid", o_valid_f, mq.size() != 0);
        if (mq.size() != 0) check("fwft_dat", o_dat_f, mq[0]);
    endtask

    task automatic step(input logic we, input logic [W-1:0] d, input logic re, input logic ce);
        logic m_empty, m_full, racc, wacc;
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == D);
        racc    = re && !m_empty;
        wacc    = we && (!m_full || racc);
        if (we && m_full && !racc) m_ovf = 1'b1;
        else if (ce)               m_ovf = 1'b0;
        if (re && m_empty)         m_unf = 1'b1;
        else if (ce)               m_unf = 1'b0;
        if (racc) sb.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        w_en    = we;
        i_dat   = d;
        r_en    = re;
        clr_err = ce;
        @(posedge r_clk);
        #1;
        check_outputs(racc);
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
    endtask

    // Asserts rst between edges, checks the asynchronous clear, releases off-edge.
    task automatic do_reset();
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b1;
        mq.delete();
        sb.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = '0;
        #2;
        check("rst_std_count", count_s, 0);
        check("rst_fwft_count", count_f, 0);
        check("rst_std_flags", {full_s, af_s, empty_s, ae_s, ovf_s, unf_s}, 6'b001100);
        check("rst_fwft_flags", {full_f, af_f, empty_f, ae_f, ovf_f, unf_f}, 6'b001100);
        check("rst_std_valid", o_valid_s, 0);
        check("rst_std_dat", o_dat_s, 0);
        check("rst_fwft_valid", o_valid_f, 0);
        @(negedge r_clk);
        rst = 1'b0;
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        w_en    = 1'b0;
        i_dat   = '0;
        r_en    = 1'b0;
        clr_err = 1'b0;

        //           we  d      re  ce  cnt val dat    unf
        vecs[0] = '{1'b1, 5'd3, 1'b0, 1'b0, 1, 1'b0, 5'd0, 1'b0};
        vecs[1] = '{1'b1, 5'd4, 1'b0, 1'b0, 2, 1'b0, 5'd0, 1'b0};
        vecs[2] = '{1'b0, 5'd0, 1'b1, 1'b0, 1, 1'b1, 5'd3, 1'b0};
        vecs[3] = '{1'b1, 5'd5, 1'b1, 1'b0, 1, 1'b1, 5'd4, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 1'b1, 1'b0, 0, 1'b1, 5'd5, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd5, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 5'd5, 1'b0};
        vecs[7] = '{1'b1, 5'd9, 1'b0, 1'b1, 1, 1'b0, 5'd5, 1'b0};

        #3;
        do_reset();

        // Hand-derived vectors on the standard-mode instance.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].we, vecs[i].d, vecs[i].re, vecs[i].ce);
            check($sformatf("vec%0d_count", i), count_s, vecs[i].e_count);
            check($sformatf("vec%0d_valid", i), o_valid_s, vecs[i].e_valid);
            check($sformatf("vec%0d_dat", i), o_dat_s, vecs[i].e_dat);
            check($sformatf("vec%0d_unf", i), unf_s, vecs[i].e_unf);
        end

        // Fill past full: 21 back-to-back writes of 7..27.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(1'b1, W'(i + 7), 1'b0, 1'b0);
            if (i == 12) check("fill_af_at13", af_s, 0);
            if (i == 13) check("fill_af_at14", af_s, 1);
            if (i == 14) check("fill_full_at15", full_s, 0);
            if (i == 15) check("fill_full_at16", full_s, 1);
        end
        check("fill_count", count_s, 16);
        check("fill_overflow", ovf_s, 1);

        // Drain with r_en held 21 cycles: 7..22, then stuck at 22.
        for (int i = 0; i < 21; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (i < 16) check("drain_seq", o_dat_s, i + 7);
            if (i == 15) check("drain_empty_at16", empty_s, 1);
        end
        check("drain_underflow", unf_s, 1);
        check("drain_hold_dat", o_dat_s, 22);
        check("drain_hold_valid", o_valid_s, 0);

        // FWFT single word: visible right after the write edge, gone after r_en.
        do_reset();
        step(1'b1, 5'd5, 1'b0, 1'b0);
        check("fwft_head_dat", o_dat_f, 5);
        check("fwft_head_valid", o_valid_f, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fwft_pop_empty", empty_f, 1);
        check("fwft_pop_valid", o_valid_f, 0);

        // Simultaneous write and read while full.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        step(1'b1, 5'd30, 1'b1, 1'b0);
        check("wr_rd_full_count", count_s, 16);
        check("wr_rd_full_ovf", ovf_s, 0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("wr_rd_full_last", o_dat_s, 30);

        // Mid-stream reset with 9 words stored and both error flags set.
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", count_s, 9);
        check("pre_rst_errs", {ovf_s, unf_s}, 2'b11);
        do_reset();
        step(1'b1, 5'd12, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_read", o_dat_s, 12);

        // clr_err colliding with a fresh overflow: set wins, then clears alone.
        for (int i = 0; i < 16; i++) step(1'b1, W'(i + 2), 1'b0, 1'b0);
        step(1'b1, 5'd31, 1'b0, 1'b1);
        check("clr_vs_set_ovf", ovf_s, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_alone_ovf", ovf_s, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
